pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage core. Merges stall requests from ID, EX and MEM into the `stall[5:0]` vector consumed by `pc_reg` and the stage registers. Sequences exception and `eret` redirects as a freeze-then-flush pair, producing `flush` and `new_pc`. An optional watchdog forces a redirect when the pipeline stays stalled too long.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_stall_wdog.sv | 15 +
 rtl/pipe_ctrl.sv | 61 ++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall masks, FSM encodings, exception codes and redirect constants for pipe_ctrl.
package pipe_ctrl_pkg;
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = 6'b111111;
  localparam logic [31:0] ExcNone  = 32'h0000_0000;
  localparam logic [31:0] ExcEret  = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
  localparam logic [15:0] WDOG_LIMIT = 16'd1024;
  typedef enum logic [1:0] {S_RUN = 2'd0, S_FREEZE = 2'd1, S_FLUSH = 2'd2} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// stall_wdog: saturating consecutive-stall counter with watchdog limit compare.
module stall_wdog
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic hit
);
  logic [15:0] scnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) scnt <= '0;
    else scnt <= en ? (scnt == 16'hFFFF ? scnt : scnt + 16'd1) : '0;
  assign hit = en && scnt == WDOG_LIMIT - 16'd1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge and freeze-then-flush redirect sequencer.
// Optional watchdog redirect enabled by defining CTRL_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_timeout
);
  state_t      state;
  logic [31:0] tgt;
  logic        wd;
  logic        wd_hit;
  logic        exc;
  logic        wd_fire;
  assign exc = excepttype_i != ExcNone;
  always_comb
    stall = state == S_FREEZE ? StallAll :
            state == S_FLUSH  ? StallNone :
            exc               ? StallAll :
            stallreq_mem_i    ? StallMem :
            stallreq_ex_i     ? StallEx :
            stallreq_id_i     ? StallId : StallNone;
`ifdef CTRL_WDOG_EN
  stall_wdog u_wdog (
    .clk (clk),
    .rst (rst),
    .en  (state == S_RUN && stall != StallNone),
    .hit (wd_hit)
  );
`else
  assign wd_hit = 1'b0;
`endif
  // an exception in the same cycle owns the redirect target
  assign wd_fire = wd_hit && !exc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_RUN;
      tgt   <= '0;
      wd    <= 1'b0;
    end else if (state == S_RUN) begin
      if (exc || wd_fire) begin
        state <= S_FREEZE;
        tgt   <= excepttype_i == ExcEret ? cp0_epc_i : EXC_VECTOR;
        wd    <= !exc;
      end
    end else begin
      state <= state == S_FREEZE ? S_FLUSH : S_RUN;
    end
  assign flush        = state == S_FLUSH;
  assign new_pc       = flush ? tgt : '0;
  assign wdog_timeout = flush && wd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush, wdog_timeout;
  logic [31:0] new_pc;
  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    excepttype_i = '0; cp0_epc_i = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b0); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL reset_wdog got=%b exp=0", wdog_timeout); end
    repeat (2) cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(); #3;
      checks++;
      if ({stall, flush, new_pc, wdog_timeout} !== 40'h0) begin
        failures++;
        $display("FAIL idle_%0d stall=%b flush=%b new_pc=%h wdog=%b exp all zero", i, stall, flush, new_pc, wdog_timeout);
      end
    end
  endtask

  task automatic test_stall_prio;
    logic [2:0] req [5] = '{3'b010, 3'b100, 3'b001, 3'b101, 3'b111};
    logic [5:0] exp [5] = '{6'b001111, 6'b011111, 6'b000111, 6'b011111, 6'b011111};
    for (int i = 0; i < 3; i++) begin
      cyc(); stallreq_id_i = 1; stallreq_ex_i = 1; #3;
      checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL id_ex_%0d stall got=%b exp=%b", i, stall, 6'b001111); end
    end
    cyc(); stallreq_id_i = 0; stallreq_ex_i = 0; #3;
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL id_ex_release stall got=%b exp=0", stall); end
    for (int i = 0; i < 5; i++) begin
      cyc(); {stallreq_mem_i, stallreq_ex_i, stallreq_id_i} = req[i]; #3;
      checks++; if (stall !== exp[i] || flush !== 1'b0) begin failures++; $display("FAIL prio_%0d stall got=%b exp=%b flush=%b", i, stall, exp[i], flush); end
    end
    cyc(); {stallreq_mem_i, stallreq_ex_i, stallreq_id_i} = 3'b000;
  endtask

  task automatic test_exception;
    cyc(); excepttype_i = 32'h8; stallreq_mem_i = 1; #3;
    checks++; if (stall !== 6'b111111 || flush !== 1'b0) begin failures++; $display("FAIL exc_T stall=%b flush=%b exp 111111/0", stall, flush); end
    cyc(); excepttype_i = 32'h0; #3;
    checks++; if (stall !== 6'b111111 || flush !== 1'b0) begin failures++; $display("FAIL exc_T1 stall=%b flush=%b exp 111111/0", stall, flush); end
    cyc(); #3;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0) begin failures++; $display("FAIL exc_T2 flush=%b new_pc=%h stall=%b exp 1/20/0", flush, new_pc, stall); end
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL exc_T2_wdog got=%b exp=0", wdog_timeout); end
    cyc(); stallreq_mem_i = 0; #3;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0 || stall !== 6'b0) begin failures++; $display("FAIL exc_T3 flush=%b new_pc=%h stall=%b exp idle", flush, new_pc, stall); end
  endtask

  task automatic test_eret;
    cyc(); excepttype_i = 32'he; cp0_epc_i = 32'h100; #3;
    checks++; if (stall !== 6'b111111) begin failures++; $display("FAIL eret_T stall got=%b exp=111111", stall); end
    cyc(); #3;
    checks++; if (stall !== 6'b111111 || flush !== 1'b0) begin failures++; $display("FAIL eret_T1 stall=%b flush=%b", stall, flush); end
    cyc(); excepttype_i = 32'h0; cp0_epc_i = 32'h0; #3;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h100) begin failures++; $display("FAIL eret_T2 flush=%b new_pc=%h exp 1/100", flush, new_pc); end
    cyc(); #3;
    checks++; if (flush !== 1'b0 || stall !== 6'b0) begin failures++; $display("FAIL eret_T3 flush=%b stall=%b exp 0/0", flush, stall); end
    cyc(); #3;
    checks++; if (flush !== 1'b0 || stall !== 6'b0) begin failures++; $display("FAIL eret_T4 flush=%b stall=%b exp 0/0", flush, stall); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] es [6] = '{6'h3f, 6'h3f, 6'h00, 6'h3f, 6'h3f, 6'h00};
    logic       ef [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cp0_epc_i = 32'h4;
    for (int i = 0; i < 6; i++) begin
      cyc(); excepttype_i = 32'h4; #3;
      checks++;
      if (stall !== es[i] || flush !== ef[i] || new_pc !== (ef[i] ? 32'h20 : 32'h0)) begin
        failures++;
        $display("FAIL b2b_%0d stall=%b flush=%b new_pc=%h exp %b/%b", i, stall, flush, new_pc, es[i], ef[i]);
      end
    end
    cyc(); excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid;
    cyc(); excepttype_i = 32'h8; #3;
    cyc(); excepttype_i = 32'h0; #3;
    checks++; if (stall !== 6'b111111) begin failures++; $display("FAIL rfz_freeze stall got=%b exp=111111", stall); end
    #1 rst = 1'b0; #1;
    checks++; if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin failures++; $display("FAIL rfz_async stall=%b flush=%b new_pc=%h exp 0", stall, flush, new_pc); end
    cyc(); cyc(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #3;
      checks++; if (flush !== 1'b0 || stall !== 6'b0) begin failures++; $display("FAIL rfz_after_%0d flush=%b stall=%b exp 0/0", i, flush, stall); end
    end
    cyc(); excepttype_i = 32'he; cp0_epc_i = 32'h100;
    cyc(); excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    cyc(); #3;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h100) begin failures++; $display("FAIL rfl_flush flush=%b new_pc=%h exp 1/100", flush, new_pc); end
    #1 rst = 1'b0; #1;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin failures++; $display("FAIL rfl_async flush=%b new_pc=%h exp 0/0", flush, new_pc); end
    cyc(); rst = 1'b1;
    cyc(); #3;
    checks++; if (flush !== 1'b0 || stall !== 6'b0) begin failures++; $display("FAIL rfl_after flush=%b stall=%b exp 0/0", flush, stall); end
  endtask

`ifdef CTRL_WDOG_EN
  task automatic test_wdog;
    int n = 1024;
    logic [5:0] xs;
    for (int k = 1; k <= n + 3; k++) begin
      cyc(); stallreq_mem_i = 1; #3;
      xs = k == n + 1 ? 6'b111111 : k == n + 2 ? 6'b0 : 6'b011111;
      checks++;
      if (stall !== xs || flush !== (k == n + 2) || wdog_timeout !== (k == n + 2) || new_pc !== (k == n + 2 ? 32'h20 : 32'h0)) begin
        failures++;
        $display("FAIL wdog_%0d stall=%b flush=%b wdog=%b new_pc=%h exp stall=%b", k, stall, flush, wdog_timeout, new_pc, xs);
      end
    end
    cyc(); stallreq_mem_i = 0;
    cyc();
  endtask
`else
  task automatic test_hold;
    for (int k = 0; k < 1200; k++) begin
      cyc(); stallreq_mem_i = 1; #3;
      checks++;
      if (stall !== 6'b011111 || flush !== 1'b0 || wdog_timeout !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d stall=%b flush=%b wdog=%b exp 011111/0/0", k, stall, flush, wdog_timeout);
      end
    end
    cyc(); stallreq_mem_i = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_stall_prio();
    test_exception();
    test_eret();
    test_back_to_back();
    test_reset_mid();
`ifdef CTRL_WDOG_EN
    test_wdog();
`else
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
